// File: rtl/rsa_pkg.sv
// Shared encodings and helpers for the output-stationary MAC array.
// Holds mode/state codes and a generic signed saturation function.
package rsa_pkg;

    localparam logic [1:0] MODE_P         = 2'b00;
    localparam logic [1:0] MODE_P_PLUS_M  = 2'b01;
    localparam logic [1:0] MODE_M_MINUS_P = 2'b10;
    localparam logic [1:0] MODE_NEG_P     = 2'b11;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] FEED  = 2'b01;
    localparam logic [1:0] FLUSH = 2'b10;
    localparam logic [1:0] DRAIN = 2'b11;

    localparam int SW = 128;

    // Clip v to the signed range of a w-bit value, result still SW wide.
    function automatic logic signed [SW-1:0] sat_to(
        input logic signed [SW-1:0] v,
        input int                   w
    );
        logic signed [SW-1:0] hi;
        logic signed [SW-1:0] lo;
        hi = (SW'(1) << (w - 1)) - SW'(1);
        lo = -hi - SW'(1);
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/pe_mac_os.sv
// Output-stationary processing element: registers operands east/south
// and accumulates their product while the travelling valid bit is set.
module pe_mac_os #(
    parameter int DW     = 32,
    parameter int ACC_DW = 68
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic signed [DW-1:0]     a_in,
    input  logic signed [DW-1:0]     b_in,
    input  logic                     v_in,
    output logic signed [DW-1:0]     a_out,
    output logic signed [DW-1:0]     b_out,
    output logic                     v_out,
    output logic signed [ACC_DW-1:0] acc
);

    logic signed [2*DW-1:0] prod;

    assign prod = a_out * b_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out <= '0;
            b_out <= '0;
            v_out <= 1'b0;
            acc   <= '0;
        end else begin
            a_out <= a_in;
            b_out <= b_in;
            v_out <= v_in;
            if (clr)
                acc <= '0;
            else if (v_out)
                acc <= acc + ACC_DW'(prod);
        end
    end

endmodule

// File: rtl/osa_mac_array.sv
// X-by-Y output-stationary systolic MAC array with skewed feed, flush,
// and a back-pressured column drain applying the fused M term.
module osa_mac_array #(
    parameter int X      = 4,
    parameter int Y      = 4,
    parameter int L_MAX  = 16,
    parameter int RSA_DW = 32,
    parameter int FRAC_W = 0,
    parameter int LW     = $clog2(L_MAX + 1),
    parameter int ACC_DW = 2 * RSA_DW + $clog2(L_MAX),
    localparam int CW    = (Y > 1) ? $clog2(Y) : 1
) (
    input  logic                  clk,
    input  logic                  sys_rst,
    input  logic                  start,
    input  logic [LW-1:0]         l_len,
    input  logic [1:0]            mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [X*RSA_DW-1:0]   A_data,
    input  logic [Y*RSA_DW-1:0]   B_data,
    input  logic [X*RSA_DW-1:0]   M_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CW-1:0]         out_col,
    output logic [X*RSA_DW-1:0]   C_data,
    output logic                  busy,
    output logic                  done
);

    import rsa_pkg::*;

    localparam int FW = $clog2(X + Y) + 1;

    logic [1:0]    state;
    logic [1:0]    mode_r;
    logic [LW-1:0] len_r;
    logic [LW-1:0] cnt;
    logic [LW-1:0] len_c;
    logic [FW-1:0] fcnt;
    logic          accept;
    logic          clr;

    logic signed [RSA_DW-1:0] a_w [X][Y+1];
    logic signed [RSA_DW-1:0] b_w [X+1][Y];
    logic                     v_w [X][Y+1];
    logic signed [ACC_DW-1:0] acc_w [X][Y];
    logic                     edge_unused;

    assign accept    = (state == FEED) && in_valid;
    assign clr       = (state == IDLE) && start;
    assign in_ready  = (state == FEED);
    assign out_valid = (state == DRAIN);
    assign busy      = (state != IDLE);
    assign len_c     = (l_len > LW'(L_MAX)) ? LW'(L_MAX) : l_len;

    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state   <= IDLE;
            mode_r  <= MODE_P;
            len_r   <= '0;
            cnt     <= '0;
            fcnt    <= '0;
            out_col <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    len_r   <= len_c;
                    mode_r  <= mode;
                    cnt     <= '0;
                    out_col <= '0;
                    state   <= (len_c == '0) ? DRAIN : FEED;
                end
                FEED: if (in_valid) begin
                    cnt <= cnt + LW'(1);
                    if (cnt + LW'(1) == len_r) begin
                        state <= FLUSH;
                        fcnt  <= '0;
                    end
                end
                FLUSH: begin
                    if (fcnt == FW'(X + Y - 2))
                        state <= DRAIN;
                    else
                        fcnt <= fcnt + FW'(1);
                end
                default: if (out_ready) begin
                    if (out_col == CW'(Y - 1)) begin
                        state   <= IDLE;
                        done    <= 1'b1;
                        out_col <= '0;
                    end else begin
                        out_col <= out_col + CW'(1);
                    end
                end
            endcase
        end
    end

    // Row i of A waits i cycles; the valid bit rides with A.
    for (genvar i = 0; i < X; i++) begin : g_askew
        if (i == 0) begin : g_d0
            assign a_w[0][0] = A_data[0 +: RSA_DW];
            assign v_w[0][0] = accept;
        end else begin : g_dn
            logic signed [RSA_DW-1:0] ad [i];
            logic                     av [i];
            always_ff @(posedge clk or negedge sys_rst) begin
                if (!sys_rst) begin
                    for (int d = 0; d < i; d++) begin
                        ad[d] <= '0;
                        av[d] <= 1'b0;
                    end
                end else begin
                    ad[0] <= A_data[i*RSA_DW +: RSA_DW];
                    av[0] <= accept;
                    for (int d = 1; d < i; d++) begin
                        ad[d] <= ad[d-1];
                        av[d] <= av[d-1];
                    end
                end
            end
            assign a_w[i][0] = ad[i-1];
            assign v_w[i][0] = av[i-1];
        end
    end

    for (genvar j = 0; j < Y; j++) begin : g_bskew
        if (j == 0) begin : g_d0
            assign b_w[0][0] = B_data[0 +: RSA_DW];
        end else begin : g_dn
            logic signed [RSA_DW-1:0] bd [j];
            always_ff @(posedge clk or negedge sys_rst) begin
                if (!sys_rst) begin
                    for (int d = 0; d < j; d++) bd[d] <= '0;
                end else begin
                    bd[0] <= B_data[j*RSA_DW +: RSA_DW];
                    for (int d = 1; d < j; d++) bd[d] <= bd[d-1];
                end
            end
            assign b_w[0][j] = bd[j-1];
        end
    end

    for (genvar i = 0; i < X; i++) begin : g_row
        for (genvar j = 0; j < Y; j++) begin : g_col
            pe_mac_os #(
                .DW     (RSA_DW),
                .ACC_DW (ACC_DW)
            ) u_pe (
                .clk   (clk),
                .rst_n (sys_rst),
                .clr   (clr),
                .a_in  (a_w[i][j]),
                .b_in  (b_w[i][j]),
                .v_in  (v_w[i][j]),
                .a_out (a_w[i][j+1]),
                .b_out (b_w[i+1][j]),
                .v_out (v_w[i][j+1]),
                .acc   (acc_w[i][j])
            );
        end
    end

    // Operands leaving the far edges of the grid have no consumer.
    always_comb begin
        edge_unused = 1'b0;
        for (int i = 0; i < X; i++)
            edge_unused = edge_unused ^ (^a_w[i][Y]) ^ v_w[i][Y];
        for (int j = 0; j < Y; j++)
            edge_unused = edge_unused ^ (^b_w[X][j]);
    end

    for (genvar i = 0; i < X; i++) begin : g_drain
        logic signed [SW-1:0] p_w;
        logic signed [SW-1:0] m_w;
        logic signed [SW-1:0] r_w;
        always_comb begin
            p_w = sat_to(SW'(acc_w[i][out_col]) >>> FRAC_W, RSA_DW);
            m_w = SW'($signed(M_data[i*RSA_DW +: RSA_DW]));
            case (mode_r)
                MODE_P:         r_w = p_w;
                MODE_P_PLUS_M:  r_w = p_w + m_w;
                MODE_M_MINUS_P: r_w = m_w - p_w;
                default:        r_w = -p_w;
            endcase
        end
        assign C_data[i*RSA_DW +: RSA_DW] = RSA_DW'(sat_to(r_w, RSA_DW));
    end

endmodule

// File: tb/tb_osa_mac_array.sv
// Directed self-checking bench for osa_mac_array (4x4/32-bit plus a
// 2x2/16-bit instance with 8 fractional bits).
module tb_osa_mac_array;

    logic         clk;
    logic         sys_rst;
    logic         start;
    logic [4:0]   l_len;
    logic [1:0]   mode;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] A_data;
    logic [127:0] B_data;
    logic [127:0] M_data;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_col;
    logic [127:0] C_data;
    logic         busy;
    logic         done;

    logic         q_start;
    logic [2:0]   q_l_len;
    logic [1:0]   q_mode;
    logic         q_in_valid;
    logic         q_in_ready;
    logic [31:0]  q_A;
    logic [31:0]  q_B;
    logic [31:0]  q_M;
    logic         q_out_valid;
    logic         q_out_ready;
    logic [0:0]   q_out_col;
    logic [31:0]  q_C;
    logic         q_busy;
    logic         q_done;

    osa_mac_array dut (
        .clk       (clk),
        .sys_rst   (sys_rst),
        .start     (start),
        .l_len     (l_len),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A_data    (A_data),
        .B_data    (B_data),
        .M_data    (M_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_col   (out_col),
        .C_data    (C_data),
        .busy      (busy),
        .done      (done)
    );

    osa_mac_array #(
        .X(2), .Y(2), .L_MAX(4), .RSA_DW(16), .FRAC_W(8)
    ) dut_q (
        .clk       (clk),
        .sys_rst   (sys_rst),
        .start     (q_start),
        .l_len     (q_l_len),
        .mode      (q_mode),
        .in_valid  (q_in_valid),
        .in_ready  (q_in_ready),
        .A_data    (q_A),
        .B_data    (q_B),
        .M_data    (q_M),
        .out_valid (q_out_valid),
        .out_ready (q_out_ready),
        .out_col   (q_out_col),
        .C_data    (q_C),
        .busy      (q_busy),
        .done      (q_done)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    int          a_m [16][4];
    int          b_m [16][4];
    int          m_m [4][4];
    logic [31:0] res [4][4];
    int          order [4];
    int          tmo;
    int          s_cyc;
    int          done_cyc;
    logic        done_now;
    logic        done_next;
    int          stall_seen;
    int          stall_bad;
    int          done_early;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic start_job(input int len, input int md);
        @(negedge clk);
        start = 1'b1;
        l_len = len[4:0];
        mode  = md[1:0];
        s_cyc = cyc;
    endtask

    task automatic feed(input int len, input bit toggle);
        int k = 0;
        int g = 0;
        bit ph = 1'b1;
        while (k < len && g < 200) begin
            @(negedge clk);
            start = 1'b0;
            g++;
            in_valid = toggle ? ph : 1'b1;
            ph = ~ph;
            for (int i = 0; i < 4; i++) begin
                A_data[i*32 +: 32] = a_m[k][i];
                B_data[i*32 +: 32] = b_m[k][i];
            end
            #1;
            if (in_valid && in_ready) k++;
        end
        if (k < len) tmo++;
    endtask

    task automatic drain(input int stall_col, input int stall_n, input bit poke);
        int hs = 0;
        int g = 0;
        int st = 0;
        logic [1:0]   c0;
        logic [127:0] d0;
        stall_seen = 0;
        stall_bad  = 0;
        done_early = 0;
        while (hs < 4 && g < 200) begin
            @(negedge clk);
            start    = 1'b0;
            in_valid = 1'b0;
            g++;
            for (int i = 0; i < 4; i++) M_data[i*32 +: 32] = m_m[out_col][i];
            out_ready = !(out_valid && out_col == stall_col[1:0] && st < stall_n);
            if (poke && hs == 1) start = 1'b1;
            #1;
            if (done) done_early++;
            if (out_valid && !out_ready) begin
                if (st == 0) begin
                    c0 = out_col;
                    d0 = C_data;
                end else if (out_col !== c0 || C_data !== d0) begin
                    stall_bad++;
                end
                st++;
                stall_seen++;
            end
            if (out_valid && out_ready) begin
                for (int i = 0; i < 4; i++) res[out_col][i] = C_data[i*32 +: 32];
                order[hs] = out_col;
                hs++;
            end
        end
        if (hs < 4) tmo++;
        @(negedge clk);
        start = 1'b0;
        #1;
        done_now = done;
        done_cyc = cyc;
        @(negedge clk);
        #1;
        done_next = done;
    endtask

    task automatic test_reset();
        sys_rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (out_col !== 2'd0) begin n_bad++; $display("FAIL reset out_col: got %0d want 0", out_col); end
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL reset busy/done: got %b/%b want 0/0", busy, done); end
        @(negedge clk);
        sys_rst = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset idle busy: got %b want 0", busy); end
    endtask

    task automatic test_identity();
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 4; i++) begin
                a_m[k][i] = (k == i) ? 1 : 0;
                b_m[k][i] = k * 4 + i + 1;
                m_m[k][i] = 0;
            end
        tmo = 0;
        start_job(4, 0);
        feed(4, 1'b0);
        drain(9, 0, 1'b0);
        n_cmp++;
        if (tmo !== 0) begin n_bad++; $display("FAIL ident timeout: got %0d want 0", tmo); end
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (res[j][i] !== 32'(i * 4 + j + 1)) begin
                    n_bad++;
                    $display("FAIL ident C[%0d][%0d]: got %0d want %0d", i, j, $signed(res[j][i]), i * 4 + j + 1);
                end
            end
        n_cmp++;
        if (done_now !== 1'b1) begin n_bad++; $display("FAIL ident done: got %b want 1", done_now); end
        n_cmp++;
        if (done_cyc - s_cyc !== 16) begin n_bad++; $display("FAIL ident latency: got %0d want 16", done_cyc - s_cyc); end
        n_cmp++;
        if (done_next !== 1'b0 || done_early !== 0) begin n_bad++; $display("FAIL ident done pulse: next %b early %0d want 0/0", done_next, done_early); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL ident busy after: got %b want 0", busy); end
    endtask

    task automatic test_modes();
        int exp_t [3] = '{28, -8, -18};
        for (int md = 1; md <= 3; md++) begin
            for (int k = 0; k < 4; k++)
                for (int i = 0; i < 4; i++) begin
                    a_m[k][i] = 2;
                    b_m[k][i] = 3;
                    m_m[k][i] = 10;
                end
            tmo = 0;
            start_job(3, md);
            feed(3, 1'b0);
            drain(9, 0, 1'b0);
            n_cmp++;
            if (tmo !== 0) begin n_bad++; $display("FAIL mode%0d timeout: got %0d want 0", md, tmo); end
            for (int j = 0; j < 4; j++)
                for (int i = 0; i < 4; i++) begin
                    n_cmp++;
                    if (res[j][i] !== 32'(exp_t[md-1])) begin
                        n_bad++;
                        $display("FAIL mode%0d C[%0d][%0d]: got %0d want %0d", md, i, j, $signed(res[j][i]), exp_t[md-1]);
                    end
                end
        end
    endtask

    task automatic test_bubbles_stall();
        int e;
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 4; i++) begin
                a_m[k][i] = int'($urandom_range(0, 200)) - 100;
                b_m[k][i] = int'($urandom_range(0, 200)) - 100;
                m_m[k][i] = 0;
            end
        tmo = 0;
        start_job(4, 0);
        feed(4, 1'b1);
        drain(2, 3, 1'b0);
        n_cmp++;
        if (tmo !== 0) begin n_bad++; $display("FAIL bubble timeout: got %0d want 0", tmo); end
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++) begin
                e = 0;
                for (int k = 0; k < 4; k++) e += a_m[k][i] * b_m[k][j];
                n_cmp++;
                if (res[j][i] !== 32'(e)) begin
                    n_bad++;
                    $display("FAIL bubble C[%0d][%0d]: got %0d want %0d", i, j, $signed(res[j][i]), e);
                end
            end
        n_cmp++;
        if (stall_seen !== 3 || stall_bad !== 0) begin n_bad++; $display("FAIL stall hold: cycles %0d changes %0d want 3/0", stall_seen, stall_bad); end
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (order[c] !== c) begin n_bad++; $display("FAIL stall order[%0d]: got %0d want %0d", c, order[c], c); end
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 16; k++)
            for (int i = 0; i < 4; i++) begin
                a_m[k][i] = 2147483647;
                b_m[k][i] = 2147483647;
            end
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 4; i++) m_m[k][i] = 0;
        tmo = 0;
        start_job(31, 0);
        feed(16, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL clamp len: in_ready %b busy %b want 0/1", in_ready, busy); end
        drain(9, 0, 1'b0);
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (res[j][i] !== 32'h7fffffff) begin
                    n_bad++;
                    $display("FAIL sat_pos C[%0d][%0d]: got %h want 7fffffff", i, j, res[j][i]);
                end
            end
        for (int i = 0; i < 4; i++) begin
            a_m[0][i] = int'(32'h80000000);
            b_m[0][i] = 2147483647;
        end
        start_job(1, 3);
        feed(1, 1'b0);
        drain(9, 0, 1'b0);
        n_cmp++;
        if (tmo !== 0) begin n_bad++; $display("FAIL sat timeout: got %0d want 0", tmo); end
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (res[j][i] !== 32'h7fffffff) begin
                    n_bad++;
                    $display("FAIL sat_neg C[%0d][%0d]: got %h want 7fffffff", i, j, res[j][i]);
                end
            end
    endtask

    task automatic test_frac();
        int g = 0;
        int got = 0;
        logic [15:0] qres [2][2];
        @(negedge clk);
        q_start = 1'b1;
        q_l_len = 3'd1;
        q_mode  = 2'b00;
        @(negedge clk);
        q_start    = 1'b0;
        q_in_valid = 1'b1;
        q_A = {16'hFFFF, 16'h0180};
        q_B = {16'h0080, 16'h0200};
        #1;
        n_cmp++;
        if (q_in_ready !== 1'b1) begin n_bad++; $display("FAIL frac in_ready: got %b want 1", q_in_ready); end
        @(negedge clk);
        q_in_valid  = 1'b0;
        q_out_ready = 1'b1;
        while (got < 2 && g < 40) begin
            @(negedge clk);
            g++;
            #1;
            if (q_out_valid && q_out_ready) begin
                qres[q_out_col][0] = q_C[15:0];
                qres[q_out_col][1] = q_C[31:16];
                got++;
            end
        end
        n_cmp++;
        if (got !== 2) begin n_bad++; $display("FAIL frac columns: got %0d want 2", got); end
        n_cmp++;
        if (qres[0][0] !== 16'h0300) begin n_bad++; $display("FAIL frac C00: got %h want 0300", qres[0][0]); end
        n_cmp++;
        if (qres[1][0] !== 16'h00C0) begin n_bad++; $display("FAIL frac C01: got %h want 00c0", qres[1][0]); end
        n_cmp++;
        if (qres[0][1] !== 16'hFFFE) begin n_bad++; $display("FAIL frac C10: got %h want fffe", qres[0][1]); end
        n_cmp++;
        if (qres[1][1] !== 16'hFFFF) begin n_bad++; $display("FAIL frac C11 floor: got %h want ffff", qres[1][1]); end
    endtask

    task automatic test_zero_len();
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++) m_m[j][i] = 5 + i;
        tmo = 0;
        start_job(0, 1);
        drain(9, 0, 1'b1);
        n_cmp++;
        if (tmo !== 0) begin n_bad++; $display("FAIL zlen timeout: got %0d want 0", tmo); end
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (res[j][i] !== 32'(5 + i)) begin
                    n_bad++;
                    $display("FAIL zlen C[%0d][%0d]: got %0d want %0d", i, j, $signed(res[j][i]), 5 + i);
                end
            end
        n_cmp++;
        if (done_cyc - s_cyc !== 5) begin n_bad++; $display("FAIL zlen latency: got %0d want 5", done_cyc - s_cyc); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL zlen start in drain: busy %b want 0", busy); end
    endtask

    task automatic test_abort();
        int bad = 0;
        int e;
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 4; i++) begin
                a_m[k][i] = 7;
                b_m[k][i] = 9;
                m_m[k][i] = 0;
            end
        tmo = 0;
        start_job(4, 0);
        feed(4, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        sys_rst = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 || out_col !== 2'd0) begin
            n_bad++;
            $display("FAIL abort state: busy %b out_valid %b in_ready %b col %0d want 0", busy, out_valid, in_ready, out_col);
        end
        @(negedge clk);
        sys_rst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (done || busy) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin n_bad++; $display("FAIL abort quiet: got %0d active cycles want 0", bad); end
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) begin
                a_m[k][i] = k * 3 + i - 4;
                b_m[k][i] = 2 * i - k + 1;
            end
        start_job(2, 0);
        feed(2, 1'b0);
        drain(9, 0, 1'b0);
        n_cmp++;
        if (tmo !== 0) begin n_bad++; $display("FAIL abort timeout: got %0d want 0", tmo); end
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++) begin
                e = a_m[0][i] * b_m[0][j] + a_m[1][i] * b_m[1][j];
                n_cmp++;
                if (res[j][i] !== 32'(e)) begin
                    n_bad++;
                    $display("FAIL abort C[%0d][%0d]: got %0d want %0d", i, j, $signed(res[j][i]), e);
                end
            end
    endtask

    initial begin
        sys_rst     = 1'b0;
        start       = 1'b0;
        l_len       = '0;
        mode        = '0;
        in_valid    = 1'b0;
        A_data      = '0;
        B_data      = '0;
        M_data      = '0;
        out_ready   = 1'b1;
        q_start     = 1'b0;
        q_l_len     = '0;
        q_mode      = '0;
        q_in_valid  = 1'b0;
        q_A         = '0;
        q_B         = '0;
        q_M         = '0;
        q_out_ready = 1'b1;
        test_reset();
        test_identity();
        test_modes();
        test_bubbles_stall();
        test_saturation();
        test_frac();
        test_zero_len();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/osa_mac_array.md
Name: osa_mac_array

Overview:
- Next-generation output-stationary systolic MAC array for the EKF matrix pipeline: computes C = op(A·B, M) for an X×L by L×Y product tile.
- Has an internal skew network, an L-beat valid/ready feed, an automatic flush, and a back-pressured column-serial drain.
- The fused M term is applied at drain, with fixed-point scaling and saturation.
- Sits between the matrix-memory sequencer and the result write-back path.

Parameters:
X, 4, array rows (rows of A / C)
Y, 4, array columns (columns of B / C)
L_MAX, 16, maximum inner dimension per tile
RSA_DW, 32, signed operand/result width
FRAC_W, 0, fractional bits; product sum is arithmetically shifted right by FRAC_W before output
LW, $clog2(L_MAX+1), width of l_len
ACC_DW, 2*RSA_DW+$clog2(L_MAX), accumulator width

Ports:
clk  in  1  clock
sys_rst  in  1  asynchronous active-low reset
start  in  1  one-cycle command pulse, accepted only in IDLE
l_len  in  LW  inner dimension, sampled on accepted start; values >L_MAX clamp to L_MAX
mode  in  2  sampled on start: 00 C=P, 01 C=P+M, 10 C=M−P, 11 C=−P
in_valid  in  1  feed beat valid
in_ready  out  1  high in FEED only
A_data  in  X*RSA_DW  column k of A, row i at [i*RSA_DW +: RSA_DW]
B_data  in  Y*RSA_DW  row k of B, column j at [j*RSA_DW +: RSA_DW]
M_data  in  X*RSA_DW  column out_col of M, must be stable while out_valid
out_valid  out  1  drain column valid
out_ready  in  1  drain back-pressure
out_col  out  $clog2(Y) (min 1)  column index being drained
C_data  out  X*RSA_DW  result column out_col, row i at [i*RSA_DW +: RSA_DW]
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on the cycle after the last column handshake

Behaviour:
- Reset state: FSM=IDLE. All accumulators, skew registers and valid bits are 0. in_ready=0, out_valid=0, out_col=0, busy=0, done=0.
- IDLE: on start, accumulators clear, l_len/mode are latched and the beat counter is reset. If l_len==0 the FSM goes directly to DRAIN; otherwise it goes to FEED. start is ignored whenever busy=1.
- FEED: in_ready=1. A beat is accepted when in_valid&in_ready. Accepted beats enter the skew network with valid=1; idle cycles inject valid=0 bubbles and do not stall the array. After beat l_len is accepted → FLUSH.
- Skew:
  - Row i of A is delayed i cycles; column j of B is delayed j cycles.
  - Each PE registers its a (east) and b (south) operands together with a valid bit.
  - A beat accepted at cycle t updates PE(i,j).acc at the clock edge ending cycle t+i+j+1.
  - PE accumulates acc += a*b only when its valid bit is 1. Products are full 2*RSA_DW signed; the accumulator is ACC_DW wide and cannot overflow for l_len ≤ L_MAX.
- FLUSH: counts X+Y−1 cycles, in_ready=0, then → DRAIN.
- DRAIN:
  - out_valid=1 and out_col steps 0..Y−1, advancing on each out_valid&out_ready.
  - C_data is a combinational function of the selected column and M_data: P_i = sat_RSA_DW(acc(i,out_col) >>> FRAC_W), i.e. arithmetic shift, floor rounding, clip to signed RSA_DW range.
  - The mode operation is computed in RSA_DW+1 bits, then saturated to RSA_DW. −P with P = −2^(RSA_DW−1) saturates to 2^(RSA_DW−1)−1.
  - After the handshake on column Y−1 → IDLE, with done=1 for one cycle in that IDLE cycle.
- With out_ready held low, C_data and out_col hold and the array is frozen.
- sys_rst asserted mid-operation (any state) returns everything to the reset state at once; no done is issued.

Decomposition:
- Shared package rsa_pkg holds the mode encodings (MODE_P, MODE_P_PLUS_M, MODE_M_MINUS_P, MODE_NEG_P), the FSM state encodings (IDLE, FEED, FLUSH, DRAIN) and a saturate-to-width function.
- One sub-module, pe_mac_os: a single output-stationary PE with operand/valid pass-through registers, clear input, and accumulator output.
- Skew lines, FSM and the drain mux/fused adder live in the top module.

Test Plan:
- X=Y=4, L=4, A=identity, B[k][j]=k*4+j+1, mode=00, out_ready=1 → columns 0..3 equal B columns; done pulses one cycle after the column-3 handshake. Total start→done = 1+4+7+4 cycles.
- L=3, all A=2, B=3, mode=01, M=10 → every C=28; mode=10 → every C=−8; mode=11 → every C=−18.
- in_valid toggled 1,0,1,0… across an L=4 feed with random A,B → results match the golden model. Then out_ready low for 3 cycles at column 2 → C_data/out_col stable, no column skipped.
- RSA_DW=16, FRAC_W=0, A=B=32767, L=16, mode=00 → C saturates to 32767. A=−32768, B=32767, mode=11 → 32767. FRAC_W=8, single product 0x0180*0x0200 → 0x0300.
- l_len=0, mode=01, M column values 5,6,7,8 → C=M immediately in DRAIN (no FEED/FLUSH). A start pulse during DRAIN is ignored.
- sys_rst asserted during FLUSH → busy=0, out_valid=0, no done. A following L=2 job produces correct results with no residue from the aborted job.
